di_pulse_meas: RTL and testbench
================================

// Module: di_pulse_meas
// PURPOSE
//  Sits directly downstream of the debounced digital-input stage on the CHK LE board IO path.
//  Consumes the clean, clk-synchronous level and produces single-cycle rise/fall strobes.
//  Also measures the width of each high pulse in clk cycles and keeps a running pulse count.
//  Feeds the IO-test reporting logic.
// PARAMETERS
//  CNT_W    16          width of pulse counter
//  WID_W    24          width of pulse-width measurement
//  TIMEOUT  24'd5000000 stuck-high limit in clk cycles (100 ms @ 50 MHz); used only with macro
// PORTS
//  clk          in   1      50 MHz system clock; single clock domain
//  rst          in   1      synchronous reset, active-high
//  in_i         in   1      debounced level, already synchronous to clk
//  clr_i        in   1      clear pulse_cnt_o and ovf_o
//  rise_o       out  1      1-cycle strobe on a measured rising edge
//  fall_o       out  1      1-cycle strobe on a falling edge
//  width_o      out  WID_W  width of the last completed high pulse
//  width_vld_o  out  1      1-cycle strobe; width_o updated this cycle
//  pulse_cnt_o  out  CNT_W  number of rising edges since reset/clear (wraps)
//  ovf_o        out  1      sticky flag; pulse_cnt_o wrapped
//  timeout_o    out  1      level; current high pulse exceeded TIMEOUT
// BEHAVIOUR
//  - Reset: every output and internal register is 0; FSM enters INIT.
//    Reset mid-pulse discards the measurement; no strobes are issued.
//  - in_i is registered once into in_d. Edges are decided on in_i vs in_d.
//  - All outputs are registered: strobes appear 1 clk after the in_i change is sampled.
//  - FSM states:
//    INIT: one cycle. Captures in_i without producing an edge.
//      in_i=0 -> LOW; in_i=1 -> SKIP.
//    SKIP: high level of unknown start. On fall: assert fall_o, no width_vld_o, go to LOW.
//    LOW: on rise: assert rise_o, set wcnt=1, go to HIGH.
//    HIGH: wcnt += 1 per high cycle; saturates at all-ones.
//      On fall: assert fall_o and width_vld_o in the same cycle; width_o <= wcnt; go to LOW.
//  - Width definition: rise sampled at cycle t and fall sampled at cycle t+N gives width_o=N.
//  - Pulse count: +1 per rise_o. Wraps from max to 0 and sets ovf_o on the wrap.
//  - clr_i zeroes pulse_cnt_o and ovf_o. If clr_i coincides with a rise, pulse_cnt_o=1.
//  - width_o holds its value between strobes; it is not cleared by clr_i.
// CONFIGURATION
//  Macro DI_PULSE_TIMEOUT_EN:
//    Defined: in HIGH or SKIP, a stuck-high counter compares against TIMEOUT.
//      timeout_o goes to 1 on the cycle the count equals TIMEOUT.
//      It holds until the fall (cleared with fall_o) or rst. State is unchanged.
//      In HIGH the width is still measured and reported on the fall.
//    Undefined: timeout_o is tied to 0 and no comparator is built. Port list is identical.
// STRUCTURE
//  Package di_pkg holds:
//    localparam state encodings S_INIT/S_LOW/S_HIGH/S_SKIP (2-bit);
//    default widths DI_CNT_W=16 and DI_WID_W=24;
//    DI_TIMEOUT_DEF.
//  Sub-module di_edge_det: in_d register plus combinational rise/fall;
//    reused by other DI-channel consumers.
//  The top level holds the FSM, counters and output registers.
// TESTING
//  1. in_i=1 through reset, release rst -> no rise_o; in_i falls -> fall_o=1, width_vld_o=0, pulse_cnt_o=0.
//  2. in_i=0, then high for 100 cycles -> rise_o once;
//     on the fall fall_o=width_vld_o=1, width_o=100, pulse_cnt_o=1.
//  3. WID_W=8, hold high 300 cycles -> width_o=255 (saturated), width_vld_o=1 at the fall.
//  4. CNT_W=4, 16 pulses -> pulse_cnt_o=0, ovf_o=1; clr_i coincident with 17th rise -> pulse_cnt_o=1, ovf_o=0.
//  5. DI_PULSE_TIMEOUT_EN, TIMEOUT=1000, high 1500 cycles -> timeout_o=1 from the 1000th high cycle;
//     on the fall timeout_o=0 and width_o=1500. Macro undefined: timeout_o stays 0.
//  6. rst asserted at high cycle 50 of a pulse -> all outputs 0 next cycle;
//     release with in_i=1 -> SKIP; the fall gives no width_vld_o.

Source files
------------

// File: rtl/di_pkg.sv
// Shared definitions for the DI pulse-measurement channel: state encodings and default widths.
package di_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_INIT = 2'd0;
  localparam state_t S_LOW  = 2'd1;
  localparam state_t S_HIGH = 2'd2;
  localparam state_t S_SKIP = 2'd3;

  localparam int unsigned DI_CNT_W       = 16;
  localparam int unsigned DI_WID_W       = 24;
  localparam int unsigned DI_TIMEOUT_DEF = 5000000;

endpackage

// File: rtl/di_edge_det.sv
// Edge detector for a clk-synchronous DI level: one delay register plus combinational strobes.
module di_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c,
  output logic fall_c
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign rise_c = level & ~level_d;
  assign fall_c = ~level & level_d;

endmodule

// File: rtl/di_pulse_meas.sv
// DI pulse measurement: rise/fall strobes, high-pulse width, pulse count with sticky wrap flag.
// Optional stuck-high detection is built only when DI_PULSE_TIMEOUT_EN is defined.
module di_pulse_meas
  import di_pkg::*;
#(
  parameter int unsigned CNT_W   = DI_CNT_W,
  parameter int unsigned WID_W   = DI_WID_W,
  parameter int unsigned TIMEOUT = DI_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  input  logic             clr_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [WID_W-1:0] width_o,
  output logic             width_vld_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic             ovf_o,
  output logic             timeout_o
);

  localparam logic [WID_W-1:0] WID_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             rise_c;
  logic             fall_c;
  logic             rise_nxt_c;
  logic             fall_nxt_c;
  logic             wvld_nxt_c;
  logic             start_c;
  logic             meas_c;
  logic [WID_W-1:0] wcnt;

  di_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .level  (in_i),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:         state_nxt = in_i ? S_SKIP : S_LOW;
      S_LOW:          if (rise_c) state_nxt = S_HIGH;
      S_HIGH, S_SKIP: if (fall_c) state_nxt = S_LOW;
      default:        state_nxt = S_INIT;
    endcase
  end

  // INIT only captures the level; a fall out of SKIP has no known start, so no width.
  always_comb begin
    rise_nxt_c = 1'b0;
    fall_nxt_c = 1'b0;
    wvld_nxt_c = 1'b0;
    start_c    = 1'b0;
    meas_c     = 1'b0;
    case (state)
      S_LOW: begin
        rise_nxt_c = rise_c;
        start_c    = rise_c;
      end
      S_HIGH: begin
        fall_nxt_c = fall_c;
        wvld_nxt_c = fall_c;
        meas_c     = ~fall_c;
      end
      S_SKIP:  fall_nxt_c = fall_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_o      <= 1'b0;
      fall_o      <= 1'b0;
      width_vld_o <= 1'b0;
      width_o     <= '0;
      wcnt        <= '0;
      pulse_cnt_o <= '0;
      ovf_o       <= 1'b0;
    end else begin
      rise_o      <= rise_nxt_c;
      fall_o      <= fall_nxt_c;
      width_vld_o <= wvld_nxt_c;
      if (start_c)                        wcnt <= WID_W'(1);
      else if (meas_c && wcnt != WID_MAX) wcnt <= wcnt + WID_W'(1);
      if (wvld_nxt_c) width_o <= wcnt;
      // A clear coinciding with a rise leaves that rise counted.
      if (clr_i) begin
        pulse_cnt_o <= CNT_W'(rise_nxt_c);
        ovf_o       <= 1'b0;
      end else if (rise_nxt_c) begin
        pulse_cnt_o <= pulse_cnt_o + CNT_W'(1);
        if (&pulse_cnt_o) ovf_o <= 1'b1;
      end
    end
  end

`ifdef DI_PULSE_TIMEOUT_EN
  localparam int unsigned    TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic            enter_c;
  logic            stuck_c;
  logic [TO_W-1:0] scnt;
  logic [TO_W-1:0] scnt_nxt;

  assign enter_c = start_c || (state == S_INIT && in_i);
  assign stuck_c = (state == S_HIGH || state == S_SKIP) && !fall_c;

  // Stuck-high counter mirrors the width count but saturates at the limit.
  always_comb begin
    scnt_nxt = scnt;
    if (enter_c)                        scnt_nxt = TO_W'(1);
    else if (stuck_c && scnt != TO_LIM) scnt_nxt = scnt + TO_W'(1);
    else if (fall_nxt_c)                scnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      scnt <= scnt_nxt;
      if (fall_nxt_c)                                     timeout_o <= 1'b0;
      else if ((enter_c || stuck_c) && scnt_nxt == TO_LIM) timeout_o <= 1'b1;
    end
  end
`else
  // TIMEOUT is still referenced so both builds share one parameter set.
  assign timeout_o = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_di_pulse_meas.sv
// Bench for di_pulse_meas: a default-width instance and a narrow (CNT_W=4, WID_W=8) instance share stimulus.
`timescale 1ns/1ps
module tb_di_pulse_meas;

  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_i;
  logic        clr_i;

  logic        rise_a, fall_a, vld_a, ovf_a, to_a;
  logic [23:0] width_a;
  logic [15:0] cnt_a;
  logic        rise_b, fall_b, vld_b, ovf_b, to_b;
  logic [7:0]  width_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise_a = 0;
  int qa[$];
  int qb[$];

  typedef struct {
    int hi;
    int lo;
    int w_a;
    int w_b;
  } vec_t;

  vec_t tbl[6];

  di_pulse_meas #(.CNT_W(16), .WID_W(24), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .in_i(in_i), .clr_i(clr_i),
    .rise_o(rise_a), .fall_o(fall_a), .width_o(width_a), .width_vld_o(vld_a),
    .pulse_cnt_o(cnt_a), .ovf_o(ovf_a), .timeout_o(to_a)
  );

  di_pulse_meas #(.CNT_W(4), .WID_W(8), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .in_i(in_i), .clr_i(clr_i),
    .rise_o(rise_b), .fall_o(fall_b), .width_o(width_b), .width_vld_o(vld_b),
    .pulse_cnt_o(cnt_b), .ovf_o(ovf_b), .timeout_o(to_b)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one high pulse of hi cycles and push the widths the two instances must report.
  task automatic pulse(input int hi, input int lo, input int wa, input int wb, input logic clr);
    in_i  = 1'b1;
    clr_i = clr;
    qa.push_back(wa);
    qb.push_back(wb);
    step(1);
    clr_i = 1'b0;
    step(hi - 1);
    in_i = 1'b0;
    step(lo);
  endtask

  // Width scoreboard: every width strobe must match the oldest pending pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rise_a) n_rise_a++;
      if (vld_a) begin
        chk("sb_pending_a", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) chk("width_a", 32'(width_a), qa.pop_front());
        chk("fall_with_vld_a", 32'(fall_a), 1);
      end
      if (vld_b) begin
        chk("sb_pending_b", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) chk("width_b", 32'(width_b), qb.pop_front());
        chk("fall_with_vld_b", 32'(fall_b), 1);
      end
    end
  end

  initial begin
    int exp_cnt;
    int exp_to;
    int r0;

    tbl[0] = '{100, 5, 100, 100};
    tbl[1] = '{1,   3, 1,   1};
    tbl[2] = '{2,   1, 2,   2};
    tbl[3] = '{300, 4, 300, 255};
    tbl[4] = '{255, 2, 255, 255};
    tbl[5] = '{256, 2, 256, 255};

`ifdef DI_PULSE_TIMEOUT_EN
    exp_to = 1;
`else
    exp_to = 0;
`endif

    // Level high through reset: no rise, fall without width.
    rst = 1'b1; in_i = 1'b1; clr_i = 1'b0;
    step(3);
    chk("rst_rise",  32'(rise_a),  0);
    chk("rst_fall",  32'(fall_a),  0);
    chk("rst_vld",   32'(vld_a),   0);
    chk("rst_width", 32'(width_a), 0);
    chk("rst_cnt",   32'(cnt_a),   0);
    chk("rst_ovf",   32'(ovf_a),   0);
    chk("rst_to",    32'(to_a),    0);
    rst = 1'b0;
    step(1);
    chk("init_no_rise", 32'(rise_a), 0);
    step(2);
    chk("skip_no_rise", n_rise_a, 0);
    in_i = 1'b0;
    step(1);
    chk("skip_fall",   32'(fall_a), 1);
    chk("skip_no_vld", 32'(vld_a),  0);
    chk("skip_cnt",    32'(cnt_a),  0);
    step(3);

    // Table of plain pulses, including saturation on the narrow instance.
    exp_cnt = 0;
    foreach (tbl[i]) begin
      r0 = n_rise_a;
      pulse(tbl[i].hi, tbl[i].lo, tbl[i].w_a, tbl[i].w_b, 1'b0);
      exp_cnt++;
      chk("rise_once",    n_rise_a - r0, 1);
      chk("cnt_a",        32'(cnt_a), exp_cnt);
      chk("width_hold_a", 32'(width_a), tbl[i].w_a);
      chk("width_hold_b", 32'(width_b), tbl[i].w_b);
    end

    // Stuck-high pulse of 1500 cycles against a limit of 1000.
    in_i = 1'b1;
    qa.push_back(1500);
    qb.push_back(255);
    step(999);
    chk("to_before", 32'(to_a), 0);
    step(1);
    chk("to_at_a", 32'(to_a), exp_to);
    chk("to_at_b", 32'(to_b), exp_to);
    step(500);
    chk("to_hold", 32'(to_a), exp_to);
    in_i = 1'b0;
    step(1);
    chk("to_clear",   32'(to_a),    0);
    chk("to_fall",    32'(fall_a),  1);
    chk("width_1500", 32'(width_a), 1500);
    step(3);

    // Clear, then wrap the 4-bit counter and clear on a coincident rise.
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("clr_cnt_a", 32'(cnt_a), 0);
    chk("clr_cnt_b", 32'(cnt_b), 0);
    chk("clr_ovf_b", 32'(ovf_b), 0);
    for (int i = 0; i < 16; i++) begin
      pulse(2, 2, 2, 2, 1'b0);
      if (i == 14) begin
        chk("cnt_b_15", 32'(cnt_b), 15);
        chk("ovf_b_15", 32'(ovf_b), 0);
      end
    end
    chk("wrap_cnt_b", 32'(cnt_b), 0);
    chk("wrap_ovf_b", 32'(ovf_b), 1);
    chk("wrap_cnt_a", 32'(cnt_a), 16);
    chk("wrap_ovf_a", 32'(ovf_a), 0);
    pulse(3, 2, 3, 3, 1'b1);
    chk("clr_rise_cnt_b", 32'(cnt_b), 1);
    chk("clr_rise_ovf_b", 32'(ovf_b), 0);
    chk("clr_rise_cnt_a", 32'(cnt_a), 1);

    // Reset in the middle of a pulse discards it; restart lands in SKIP.
    r0 = n_rise_a;
    in_i = 1'b1;
    step(50);
    rst = 1'b1;
    step(1);
    chk("mid_rst_width_a", 32'(width_a), 0);
    chk("mid_rst_width_b", 32'(width_b), 0);
    chk("mid_rst_cnt_a",   32'(cnt_a),   0);
    chk("mid_rst_rise",    32'(rise_a),  0);
    chk("mid_rst_fall",    32'(fall_a),  0);
    chk("mid_rst_vld",     32'(vld_a),   0);
    rst = 1'b0;
    step(4);
    chk("mid_rst_no_rise", n_rise_a - r0, 1);
    in_i = 1'b0;
    step(1);
    chk("mid_rst_fall_after", 32'(fall_a), 1);
    chk("mid_rst_no_vld",     32'(vld_a),  0);
    chk("mid_rst_cnt_after",  32'(cnt_a),  0);
    step(3);

    chk("sb_empty_a", qa.size(), 0);
    chk("sb_empty_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
